move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler_pkg.sv | 50 +++++
 rtl/move_scheduler.sv | 177 +++++++++++++++++
 tb/tb_move_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/move_scheduler_pkg.sv
// +--------------------------------------------------------------------+
// | move_scheduler_pkg : shared move/block types and scheduler states   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package move_scheduler_pkg;

  localparam int KIND_W = 3;
  localparam int ROT_W  = 2;
  localparam int X_W    = 4;
  localparam int Y_W    = 5;

  typedef enum logic [2:0] {
    MOVE_LEFT   = 3'd0,
    MOVE_RIGHT  = 3'd1,
    MOVE_DOWN   = 3'd2,
    MOVE_ROTATE = 3'd3,
    MOVE_APPEAR = 3'd4
  } move_t;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [ROT_W-1:0]  rotation;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
  } block_info_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_APPLY = 2'd3
  } sched_state_t;

  // Coordinates wrap modulo the field width; the checker is trusted to
  // only grant moves that stay on the board.
  function automatic logic [X_W-1:0] add_x(input logic [X_W-1:0] base,
                                           input logic signed [1:0] d);
    return base + {{(X_W-2){d[1]}}, d};
  endfunction

  function automatic logic [Y_W-1:0] add_y(input logic [Y_W-1:0] base,
                                           input logic signed [1:0] d);
    return base + {{(Y_W-2){d[1]}}, d};
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_scheduler.sv
// +--------------------------------------------------------------------+
// | move_scheduler : arbitrates appear/gravity/user moves through an    |
// | external move checker and writes back the updated block. Rev 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              appear_i,
  input  logic              gravity_tick_i,
  input  logic              user_valid_i,
  input  move_t             user_move_i,
  output logic              user_ready_o,
  input  block_info_t       block_i,
  output logic              check_run_o,
  output move_t             check_move_o,
  input  logic              check_done_i,
  input  logic              check_can_move_i,
  input  logic signed [1:0] check_move_x_i,
  input  logic signed [1:0] check_move_y_i,
  output block_info_t       block_o,
  output logic              block_upd_o,
  output logic              lock_o,
  output logic              reject_o,
  output logic              game_over_o,
  output logic              busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t      state_q, state_d;
  move_t             move_q, move_d;
  logic              pend_appear_q, pend_appear_d;
  logic              pend_grav_q, pend_grav_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              can_q, can_d;
  logic signed [1:0] mx_q, mx_d;
  logic signed [1:0] my_q, my_d;
  block_info_t       block_q, block_d;
  logic              block_upd_q, block_upd_d;
  logic              lock_q, lock_d;
  logic              reject_q, reject_d;
  logic              game_over_q, game_over_d;

  logic w_appear_req;
  logic w_grav_req;
  logic w_user_ready;

  // Raw pulses count as requests in the same cycle so an idle scheduler
  // reacts immediately and a user handshake is never granted under them.
  assign w_appear_req = pend_appear_q | appear_i;
  assign w_grav_req   = pend_grav_q | gravity_tick_i;
  assign w_user_ready = (state_q == ST_IDLE) & ~w_appear_req & ~w_grav_req & ~game_over_q;

  always_comb begin
    state_d       = state_q;
    move_d        = move_q;
    pend_appear_d = w_appear_req;
    pend_grav_d   = w_grav_req;
    cnt_d         = cnt_q;
    can_d         = can_q;
    mx_d          = mx_q;
    my_d          = my_q;
    block_d       = block_q;
    block_upd_d   = 1'b0;
    lock_d        = 1'b0;
    reject_d      = 1'b0;
    game_over_d   = game_over_q;

    case (state_q)
      ST_IDLE: begin
        if (w_appear_req) begin
          move_d        = MOVE_APPEAR;
          pend_appear_d = 1'b0;
          state_d       = ST_ISSUE;
        end else if (w_grav_req && !game_over_q) begin
          move_d      = MOVE_DOWN;
          pend_grav_d = 1'b0;
          state_d     = ST_ISSUE;
        end else if (user_valid_i && w_user_ready) begin
          move_d  = user_move_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (check_done_i) begin
          can_d   = check_can_move_i;
          mx_d    = check_move_x_i;
          my_d    = check_move_y_i;
          state_d = ST_APPLY;
        end else if (cnt_q == C_CNT_LAST) begin
          reject_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        if (can_q) begin
          block_d   = block_i;
          block_d.x = add_x(block_i.x, mx_q);
          block_d.y = add_y(block_i.y, my_q);
          if (move_q == MOVE_ROTATE) begin
            block_d.rotation = block_i.rotation + ROT_W'(1);
          end
          block_upd_d = 1'b1;
          if (move_q == MOVE_APPEAR) begin
            game_over_d = 1'b0;
          end
        end else if (move_q == MOVE_DOWN) begin
          lock_d = 1'b1;
        end else if (move_q == MOVE_APPEAR) begin
          game_over_d = 1'b1;
        end else begin
          reject_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      move_q        <= MOVE_LEFT;
      pend_appear_q <= 1'b0;
      pend_grav_q   <= 1'b0;
      cnt_q         <= '0;
      can_q         <= 1'b0;
      mx_q          <= '0;
      my_q          <= '0;
      block_q       <= '0;
      block_upd_q   <= 1'b0;
      lock_q        <= 1'b0;
      reject_q      <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      move_q        <= move_d;
      pend_appear_q <= pend_appear_d;
      pend_grav_q   <= pend_grav_d;
      cnt_q         <= cnt_d;
      can_q         <= can_d;
      mx_q          <= mx_d;
      my_q          <= my_d;
      block_q       <= block_d;
      block_upd_q   <= block_upd_d;
      lock_q        <= lock_d;
      reject_q      <= reject_d;
      game_over_q   <= game_over_d;
    end
  end

  assign user_ready_o = w_user_ready;
  assign check_run_o  = (state_q == ST_ISSUE);
  assign check_move_o = move_q;
  assign block_o      = block_q;
  assign block_upd_o  = block_upd_q;
  assign lock_o       = lock_q;
  assign reject_o     = reject_q;
  assign game_over_o  = game_over_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_move_scheduler.sv
// +--------------------------------------------------------------------+
// | tb_move_scheduler : directed table + sequences for move_scheduler   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_move_scheduler;
  import move_scheduler_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              appear_i = 1'b0;
  logic              gravity_tick_i = 1'b0;
  logic              user_valid_i = 1'b0;
  move_t             user_move_i = MOVE_LEFT;
  logic              user_ready_o;
  block_info_t       block_i = '0;
  logic              check_run_o;
  move_t             check_move_o;
  logic              check_done_i = 1'b0;
  logic              check_can_move_i = 1'b0;
  logic signed [1:0] check_move_x_i = '0;
  logic signed [1:0] check_move_y_i = '0;
  block_info_t       block_o;
  logic              block_upd_o;
  logic              lock_o;
  logic              reject_o;
  logic              game_over_o;
  logic              busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  move_scheduler #(.TIMEOUT_CYCLES(31)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .appear_i(appear_i),
    .gravity_tick_i(gravity_tick_i), .user_valid_i(user_valid_i),
    .user_move_i(user_move_i), .user_ready_o(user_ready_o), .block_i(block_i),
    .check_run_o(check_run_o), .check_move_o(check_move_o),
    .check_done_i(check_done_i), .check_can_move_i(check_can_move_i),
    .check_move_x_i(check_move_x_i), .check_move_y_i(check_move_y_i),
    .block_o(block_o), .block_upd_o(block_upd_o), .lock_o(lock_o),
    .reject_o(reject_o), .game_over_o(game_over_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]        src;  // 0 user, 1 gravity, 2 appear
    move_t             mv;
    block_info_t       blk;
    logic              can;
    logic signed [1:0] mx;
    logic signed [1:0] my;
    block_info_t       exp_blk;
    logic              upd;
    logic              lock;
    logic              rej;
  } vec_t;

  vec_t vecs[11];

  function automatic block_info_t mk(input int k, input int r, input int x, input int y);
    block_info_t b;
    b.kind     = KIND_W'(k);
    b.rotation = ROT_W'(r);
    b.x        = X_W'(x);
    b.y        = Y_W'(y);
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Bench acts as the checker: done one cycle after run, then two edges to output.
  task automatic finish_check(input logic can, input logic signed [1:0] mx,
                              input logic signed [1:0] my);
    @(posedge clk_i); #1;
    check_done_i = 1'b1; check_can_move_i = can;
    check_move_x_i = mx; check_move_y_i = my;
    @(posedge clk_i); #1;
    check_done_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
  endtask

  task automatic pulse_req(input logic [1:0] src, input move_t mv, input block_info_t b);
    @(posedge clk_i); #1;
    block_i = b;
    case (src)
      2'd1:    gravity_tick_i = 1'b1;
      2'd2:    appear_i = 1'b1;
      default: begin user_valid_i = 1'b1; user_move_i = mv; end
    endcase
    @(posedge clk_i); #1;
    gravity_tick_i = 1'b0; appear_i = 1'b0; user_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    vecs[0]  = '{2'd0, MOVE_RIGHT,  mk(1,0,4,2),  1'b1, 2'sd1,  2'sd0,  mk(1,0,5,2),  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, MOVE_LEFT,   mk(1,0,5,2),  1'b1, -2'sd1, 2'sd0,  mk(1,0,4,2),  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'd1, MOVE_DOWN,   mk(1,0,4,2),  1'b1, 2'sd0,  2'sd1,  mk(1,0,4,3),  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'd1, MOVE_DOWN,   mk(1,0,4,3),  1'b0, 2'sd0,  2'sd1,  mk(1,0,4,3),  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{2'd0, MOVE_ROTATE, mk(1,3,4,3),  1'b1, 2'sd0,  2'sd0,  mk(1,0,4,3),  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'd0, MOVE_LEFT,   mk(2,1,0,7),  1'b1, -2'sd1, 2'sd0,  mk(2,1,15,7), 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{2'd0, MOVE_RIGHT,  mk(2,1,15,7), 1'b0, 2'sd1,  2'sd0,  mk(2,1,15,7), 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'd0, MOVE_DOWN,   mk(2,1,15,31),1'b1, 2'sd0,  2'sd1,  mk(2,1,15,0), 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'd2, MOVE_APPEAR, mk(3,0,3,0),  1'b1, 2'sd0,  2'sd0,  mk(3,0,3,0),  1'b1, 1'b0, 1'b0};
    vecs[9]  = '{2'd0, MOVE_ROTATE, mk(3,1,3,0),  1'b0, 2'sd0,  2'sd0,  mk(3,0,3,0),  1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'd0, MOVE_ROTATE, mk(3,1,3,0),  1'b1, 2'sd0,  -2'sd1, mk(3,2,3,31), 1'b1, 1'b0, 1'b0};

    // Reset state
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_run", check_run_o, 0);
    chk("rst_block", block_o, 0);
    chk("rst_pulses", {block_upd_o, lock_o, reject_o, game_over_o}, 0);
    @(posedge clk_i); #1; rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", user_ready_o, 1);

    for (int i = 0; i < 11; i++) begin
      pulse_req(vecs[i].src, vecs[i].mv, vecs[i].blk);
      chk($sformatf("v%0d_run", i), check_run_o, 1);
      chk($sformatf("v%0d_move", i), check_move_o, vecs[i].mv);
      finish_check(vecs[i].can, vecs[i].mx, vecs[i].my);
      chk($sformatf("v%0d_upd", i), block_upd_o, vecs[i].upd);
      chk($sformatf("v%0d_lock", i), lock_o, vecs[i].lock);
      chk($sformatf("v%0d_rej", i), reject_o, vecs[i].rej);
      chk($sformatf("v%0d_blk", i), block_o, vecs[i].exp_blk);
      chk($sformatf("v%0d_gover", i), game_over_o, 0);
      chk($sformatf("v%0d_busy", i), busy_o, 0);
      @(negedge clk_i);
      chk($sformatf("v%0d_pulse_end", i), {block_upd_o, lock_o, reject_o}, 0);
    end

    // Gravity and user in the same cycle: DOWN first, user waits
    @(posedge clk_i); #1;
    block_i = mk(1,0,4,3); gravity_tick_i = 1'b1;
    user_valid_i = 1'b1; user_move_i = MOVE_RIGHT;
    @(negedge clk_i);
    chk("pri_ready_tick", user_ready_o, 0);
    @(posedge clk_i); #1; gravity_tick_i = 1'b0;
    @(negedge clk_i);
    chk("pri_move_down", check_move_o, MOVE_DOWN);
    chk("pri_ready_issue", user_ready_o, 0);
    @(posedge clk_i); #1;
    check_done_i = 1'b1; check_can_move_i = 1'b1; check_move_x_i = 2'sd0; check_move_y_i = 2'sd1;
    @(negedge clk_i);
    chk("pri_ready_wait", user_ready_o, 0);
    @(posedge clk_i); #1; check_done_i = 1'b0;
    @(negedge clk_i);
    chk("pri_ready_apply", user_ready_o, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("pri_down_upd", block_upd_o, 1);
    chk("pri_down_blk", block_o, mk(1,0,4,4));
    chk("pri_ready_after", user_ready_o, 1);
    @(posedge clk_i); #1; user_valid_i = 1'b0; block_i = mk(1,0,4,4);
    @(negedge clk_i);
    chk("pri_user_run", check_run_o, 1);
    chk("pri_user_move", check_move_o, MOVE_RIGHT);
    finish_check(1'b1, 2'sd1, 2'sd0);
    chk("pri_user_blk", block_o, mk(1,0,5,4));

    // Failed APPEAR sets game over; only APPEAR is served until it clears
    pulse_req(2'd2, MOVE_APPEAR, mk(4,0,3,0));
    chk("go_move", check_move_o, MOVE_APPEAR);
    finish_check(1'b0, 2'sd0, 2'sd0);
    chk("go_set", game_over_o, 1);
    chk("go_no_upd", {block_upd_o, lock_o, reject_o}, 0);
    @(posedge clk_i); #1;
    user_valid_i = 1'b1; user_move_i = MOVE_LEFT; gravity_tick_i = 1'b1;
    @(posedge clk_i); #1; gravity_tick_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk($sformatf("go_ready_%0d", c), user_ready_o, 0);
      chk($sformatf("go_idle_%0d", c), busy_o, 0);
    end
    @(posedge clk_i); #1; user_valid_i = 1'b0;
    pulse_req(2'd2, MOVE_APPEAR, mk(4,0,3,0));
    chk("go_appear_move", check_move_o, MOVE_APPEAR);
    finish_check(1'b1, 2'sd0, 2'sd0);
    chk("go_cleared", game_over_o, 0);
    chk("go_appear_blk", block_o, mk(4,0,3,0));
    @(negedge clk_i);
    chk("go_grav_run", check_run_o, 1);
    chk("go_grav_move", check_move_o, MOVE_DOWN);
    finish_check(1'b1, 2'sd0, 2'sd1);
    chk("go_grav_blk", block_o, mk(4,0,3,1));

    // Checker never answers: reject after 31 WAIT cycles
    pulse_req(2'd0, MOVE_RIGHT, mk(4,0,3,1));
    chk("to_run", check_run_o, 1);
    begin
      int n;
      n = 0;
      while (!reject_o && n < 40) begin
        @(negedge clk_i);
        n++;
        if (n == 31) chk("to_busy_last_wait", busy_o, 1);
      end
      chk("to_cycles", n, 32);
    end
    chk("to_reject", reject_o, 1);
    chk("to_no_upd", block_upd_o, 0);
    chk("to_idle", busy_o, 0);
    chk("to_blk", block_o, mk(4,0,3,1));
    @(posedge clk_i); #1;
    check_done_i = 1'b1; check_can_move_i = 1'b1; check_move_x_i = 2'sd1;
    @(posedge clk_i); #1; check_done_i = 1'b0;
    @(negedge clk_i);
    chk("stray_busy", busy_o, 0);
    @(negedge clk_i);
    chk("stray_upd", {block_upd_o, lock_o, reject_o}, 0);

    // Reset mid-WAIT clears everything immediately
    pulse_req(2'd2, MOVE_APPEAR, mk(5,0,2,0));
    finish_check(1'b0, 2'sd0, 2'sd0);
    chk("rw_gover", game_over_o, 1);
    pulse_req(2'd2, MOVE_APPEAR, mk(5,0,2,0));
    @(posedge clk_i); #1;
    chk("rw_in_wait", busy_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("rw_busy", busy_o, 0);
    chk("rw_run", check_run_o, 0);
    chk("rw_gover_clr", game_over_o, 0);
    chk("rw_block", block_o, 0);
    chk("rw_pulses", {block_upd_o, lock_o, reject_o}, 0);
    @(posedge clk_i); #1; rst_n_i = 1'b1;
    check_done_i = 1'b1; check_can_move_i = 1'b1;
    @(posedge clk_i); #1; check_done_i = 1'b0;
    @(negedge clk_i);
    chk("rw_stray_busy", busy_o, 0);
    @(negedge clk_i);
    chk("rw_stray_upd", {block_upd_o, block_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
